// File: rtl/wb_merge.sv
// Writeback merge: ALU results take the register-file write port first,
// load returns queue in an in-order FIFO and drain into idle slots.
module wb_merge #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_vld,
   input  logic [2:0]               alu_trd,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   input  logic                     ld_vld,
   input  logic [2:0]               ld_trd,
   input  logic [4:0]               ld_rd,
   input  logic [31:0]              ld_data,
   output logic                     ld_rdy,
   output logic                     wr_en,
   output logic [2:0]               wr_trd,
   output logic [4:0]               reg_wr,
   output logic [31:0]              wr_data,
   output logic [$clog2(DEPTH):0]   ld_cnt,
   output logic [7:0]               trd_pend,
   output logic                     alu_hold
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [2:0]       trd_q  [DEPTH];
   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             hold_q, hold_d;
   logic             wen_q, wen_d;
   logic [2:0]       wtrd_q, wtrd_d;
   logic [4:0]       wrd_q, wrd_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             alu_sel, push, pop, fifo_ne;

   assign fifo_ne = (cnt_q != '0);
   assign ld_rdy  = (cnt_q != CW'(DEPTH));
   assign alu_sel = alu_vld && (alu_rd != 5'd0);
   // rd==0 loads still complete the handshake but are never stored
   assign push    = ld_vld && ld_rdy && (ld_rd != 5'd0);
   assign pop     = !alu_sel && fifo_ne;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;
      if (push) begin
         wptr_d        = wptr_q + 1'b1;
         vld_d[wptr_q] = 1'b1;
      end
      if (pop) begin
         rptr_d        = rptr_q + 1'b1;
         vld_d[rptr_q] = 1'b0;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (pop || !fifo_ne)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + 1'b1;
      hold_d = (starve_q == SW'(STARVE_MAX)) && !pop;
   end

   always_comb begin
      wen_d   = 1'b0;
      wtrd_d  = wtrd_q;
      wrd_d   = wrd_q;
      wdata_d = wdata_q;
      if (alu_sel) begin
         wen_d   = 1'b1;
         wtrd_d  = alu_trd;
         wrd_d   = alu_rd;
         wdata_d = alu_data;
      end else if (pop) begin
         wen_d   = 1'b1;
         wtrd_d  = trd_q[rptr_q];
         wrd_d   = rd_q[rptr_q];
         wdata_d = data_q[rptr_q];
      end
   end

   always_comb begin
      trd_pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld_q[i]) trd_pend[trd_q[i]] = 1'b1;
   end

   // Payload storage needs no reset; occupancy is tracked by vld_q
   always_ff @(posedge clk) begin
      if (push) begin
         trd_q[wptr_q]  <= ld_trd;
         rd_q[wptr_q]   <= ld_rd;
         data_q[wptr_q] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         vld_q    <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         hold_q   <= 1'b0;
         wen_q    <= 1'b0;
         wtrd_q   <= '0;
         wrd_q    <= '0;
         wdata_q  <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         vld_q    <= vld_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         hold_q   <= hold_d;
         wen_q    <= wen_d;
         wtrd_q   <= wtrd_d;
         wrd_q    <= wrd_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wr_en    = wen_q;
   assign wr_trd   = wtrd_q;
   assign reg_wr   = wrd_q;
   assign wr_data  = wdata_q;
   assign ld_cnt   = cnt_q;
   assign alu_hold = hold_q;

endmodule
